// File: rtl/neuron_act.sv
// neuron_act: per-lane activation (linear / ReLU / leaky / clip) clamped to WO bits, feeding two
// independent 1-entry output slots. Define NEURON_ACT_SATCNT_EN to build the saturated-lane counter.
module neuron_act #(
  parameter int    NP       = 4,
  parameter int    NC       = 4,
  parameter int    WF       = 4,
  parameter int    WO       = 4,
  parameter int    LEAK_SH  = 2,
  parameter int    CLIP_MAX = 6,
  parameter string BURST    = "yes",
  localparam int   WI       = $clog2(NP) + 1 + WF
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iMode,
  input  logic [1:0]      iAct,
  input  logic            iClrSat,
  input  logic            iValid_AM_Accum0,
  output logic            oReady_AM_Accum0,
  input  logic [NC*WI-1:0] iData_AM_Accum0,
  output logic            oValid_BM_State0,
  input  logic            iReady_BM_State0,
  output logic [NC*WO-1:0] oData_BM_State0,
  output logic            oValid_BM_State1,
  input  logic            iReady_BM_State1,
  output logic [NC*WO-1:0] oData_BM_State1,
  output logic [15:0]     oSatCnt
);

  localparam int MAXI  = 2 ** (WO - 1) - 1;
  localparam int MINI  = -(2 ** (WO - 1));
  localparam int CLIPI = (CLIP_MAX < MAXI) ? CLIP_MAX : MAXI;
  localparam logic signed [WI-1:0] MAXV  = WI'(MAXI);
  localparam logic signed [WI-1:0] MINV  = WI'(MINI);
  localparam logic signed [WI-1:0] CLIPV = WI'(CLIPI);
  localparam bit BURST_EN = (BURST == "yes");

  logic signed [WI-1:0] laneIn, laneOut, leaky;
  logic [NC*WO-1:0] actData;
  logic [NC-1:0]    laneSat;
  logic             satHit;

  // Negative inputs forced to zero by ReLU/clip are not clamps and never flag saturation.
  always_comb begin
    actData = '0;
    laneSat = '0;
    laneIn  = '0;
    laneOut = '0;
    leaky   = '0;
    satHit  = 1'b0;
    for (int i = 0; i < NC; i++) begin
      laneIn  = iData_AM_Accum0[i*WI +: WI];
      leaky   = laneIn >>> LEAK_SH;
      laneOut = laneIn;
      satHit  = 1'b0;
      case (iAct)
        2'd0: begin
          if (laneIn > MAXV) begin
            laneOut = MAXV;
            satHit  = 1'b1;
          end else if (laneIn < MINV) begin
            laneOut = MINV;
            satHit  = 1'b1;
          end
        end
        2'd1: begin
          if (laneIn < 0) begin
            laneOut = '0;
          end else if (laneIn > MAXV) begin
            laneOut = MAXV;
            satHit  = 1'b1;
          end
        end
        2'd2: begin
          if (laneIn < 0) begin
            if (leaky < MINV) begin
              laneOut = MINV;
              satHit  = 1'b1;
            end else begin
              laneOut = leaky;
            end
          end else if (laneIn > MAXV) begin
            laneOut = MAXV;
            satHit  = 1'b1;
          end
        end
        default: begin
          if (laneIn < 0) begin
            laneOut = '0;
          end else if (laneIn > CLIPV) begin
            laneOut = CLIPV;
            satHit  = 1'b1;
          end
        end
      endcase
      actData[i*WO +: WO] = laneOut[WO-1:0];
      laneSat[i]          = satHit;
    end
  end

  logic valid0, valid1, slot0Free, slot1Free, accept;
  logic [NC*WO-1:0] data0, data1;

  // Slot 1 only gates acceptance when the incoming beat is a TRAIN beat.
  assign slot0Free        = !valid0 || (BURST_EN && iReady_BM_State0);
  assign slot1Free        = !valid1 || (BURST_EN && iReady_BM_State1);
  assign oReady_AM_Accum0 = slot0Free && (!iMode || slot1Free);
  assign accept           = iValid_AM_Accum0 && oReady_AM_Accum0;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      valid0 <= 1'b0;
      valid1 <= 1'b0;
      data0  <= '0;
      data1  <= '0;
    end else begin
      if (accept) begin
        valid0 <= 1'b1;
        data0  <= actData;
      end else if (valid0 && iReady_BM_State0) begin
        valid0 <= 1'b0;
      end
      if (accept && iMode) begin
        valid1 <= 1'b1;
        data1  <= actData;
      end else if (valid1 && iReady_BM_State1) begin
        valid1 <= 1'b0;
      end
    end
  end

  assign oValid_BM_State0 = valid0;
  assign oValid_BM_State1 = valid1;
  assign oData_BM_State0  = data0;
  assign oData_BM_State1  = data1;

`ifdef NEURON_ACT_SATCNT_EN
  logic [15:0] satCnt, satNum;
  logic [16:0] satSum;

  always_comb begin
    satNum = '0;
    for (int i = 0; i < NC; i++) begin
      satNum = satNum + 16'(laneSat[i]);
    end
    satSum = {1'b0, satCnt} + {1'b0, satNum};
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      satCnt <= '0;
    end else if (iClrSat) begin
      satCnt <= '0;
    end else if (accept) begin
      satCnt <= satSum[16] ? 16'hFFFF : satSum[15:0];
    end
  end

  assign oSatCnt = satCnt;
`else
  logic unusedSat;
  assign unusedSat = ^{laneSat, iClrSat};
  assign oSatCnt   = '0;
`endif

endmodule

// File: tb/tb_neuron_act.sv
// Directed testbench for neuron_act (NP=4, NC=2, WF=4, WO=4 -> WI=7, range -8..7).
// Counter expectations follow whether NEURON_ACT_SATCNT_EN is defined for the build.
module tb_neuron_act;

  localparam int NP = 4;
  localparam int NC = 2;
  localparam int WF = 4;
  localparam int WO = 4;
  localparam int WI = 7;

  logic iCLK = 1'b0;
  logic iRST = 1'b0;
  logic iMode = 1'b0;
  logic [1:0] iAct = 2'd0;
  logic iClrSat = 1'b0;
  logic iValid_AM_Accum0 = 1'b0;
  logic oReady_AM_Accum0;
  logic [NC*WI-1:0] iData_AM_Accum0 = '0;
  logic oValid_BM_State0;
  logic iReady_BM_State0 = 1'b1;
  logic [NC*WO-1:0] oData_BM_State0;
  logic oValid_BM_State1;
  logic iReady_BM_State1 = 1'b1;
  logic [NC*WO-1:0] oData_BM_State1;
  logic [15:0] oSatCnt;

  int passCount = 0;
  int checkCount = 0;

  neuron_act #(.NP(NP), .NC(NC), .WF(WF), .WO(WO), .LEAK_SH(2), .CLIP_MAX(6), .BURST("yes")) dut (
    .iCLK(iCLK), .iRST(iRST), .iMode(iMode), .iAct(iAct), .iClrSat(iClrSat),
    .iValid_AM_Accum0(iValid_AM_Accum0), .oReady_AM_Accum0(oReady_AM_Accum0),
    .iData_AM_Accum0(iData_AM_Accum0),
    .oValid_BM_State0(oValid_BM_State0), .iReady_BM_State0(iReady_BM_State0),
    .oData_BM_State0(oData_BM_State0),
    .oValid_BM_State1(oValid_BM_State1), .iReady_BM_State1(iReady_BM_State1),
    .oData_BM_State1(oData_BM_State1),
    .oSatCnt(oSatCnt)
  );

  always #5 iCLK = ~iCLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic valid, input logic mode, input logic [1:0] act,
                               input int lane0, input int lane1);
    iValid_AM_Accum0 = valid;
    iMode            = mode;
    iAct             = act;
    iData_AM_Accum0  = {WI'(lane1), WI'(lane0)};
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic checkSat(input string tag, input logic [15:0] expected);
`ifdef NEURON_ACT_SATCNT_EN
    checkOutput(tag, oSatCnt, expected);
`else
    checkOutput(tag, oSatCnt, 16'h0);
`endif
  endtask

  initial begin
    logic [7:0] expData;
    $display("[TB] neuron_act directed test start");

    // Reset state
    #1;
    checkOutput("rst_v0", oValid_BM_State0, 1'b0);
    checkOutput("rst_v1", oValid_BM_State1, 1'b0);
    checkOutput("rst_d0", oData_BM_State0, 8'h00);
    checkOutput("rst_d1", oData_BM_State1, 8'h00);
    checkOutput("rst_sat", oSatCnt, 16'h0);
    checkOutput("rst_ready", oReady_AM_Accum0, 1'b1);
    #2 iRST = 1'b1;

    // ReLU, TRAIN, {+20,-5} -> {7,0} on both outputs, one saturation
    applyStimulus(1'b1, 1'b1, 2'd1, 20, -5);
    tick();
    checkOutput("relu_v0", oValid_BM_State0, 1'b1);
    checkOutput("relu_v1", oValid_BM_State1, 1'b1);
    checkOutput("relu_d0", oData_BM_State0, 8'h07);
    checkOutput("relu_d1", oData_BM_State1, 8'h07);
    checkSat("relu_sat", 16'd1);
    applyStimulus(1'b0, 1'b1, 2'd1, 0, 0);
    tick();
    checkOutput("relu_drain_v0", oValid_BM_State0, 1'b0);
    checkOutput("relu_drain_v1", oValid_BM_State1, 1'b0);

    // Linear / leaky / clip back-to-back in TEST
    iClrSat = 1'b1;
    tick();
    iClrSat = 1'b0;
    checkSat("clr_sat", 16'd0);
    applyStimulus(1'b1, 1'b0, 2'd0, -20, 3);
    tick();
    checkOutput("lin_d0", oData_BM_State0, 8'h38);
    checkOutput("lin_v1", oValid_BM_State1, 1'b0);
    checkSat("lin_sat", 16'd1);
    checkOutput("lin_ready", oReady_AM_Accum0, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'd2, -12, 5);
    tick();
    checkOutput("leaky_d0", oData_BM_State0, 8'h5D);
    checkSat("leaky_sat", 16'd1);
    applyStimulus(1'b1, 1'b0, 2'd3, 9, -1);
    tick();
    checkOutput("clip_d0", oData_BM_State0, 8'h06);
    checkOutput("clip_v0", oValid_BM_State0, 1'b1);
    checkSat("clip_sat", 16'd2);
    applyStimulus(1'b0, 1'b0, 2'd0, 0, 0);
    tick();

    // TRAIN with State1 stalled: State0 drains, input stalls, no loss/duplication
    iReady_BM_State1 = 1'b0;
    applyStimulus(1'b1, 1'b1, 2'd0, 1, 2);
    tick();
    checkOutput("stall_a_v0", oValid_BM_State0, 1'b1);
    checkOutput("stall_a_v1", oValid_BM_State1, 1'b1);
    checkOutput("stall_a_d0", oData_BM_State0, 8'h21);
    checkOutput("stall_a_d1", oData_BM_State1, 8'h21);
    checkOutput("stall_ready0", oReady_AM_Accum0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd0, 3, 4);
    for (int k = 0; k < 2; k++) begin
      tick();
      checkOutput("stall_hold_v0", oValid_BM_State0, 1'b0);
      checkOutput("stall_hold_v1", oValid_BM_State1, 1'b1);
      checkOutput("stall_hold_d1", oData_BM_State1, 8'h21);
      checkOutput("stall_hold_ready", oReady_AM_Accum0, 1'b0);
    end
    iReady_BM_State1 = 1'b1;
    #1;
    checkOutput("stall_release_ready", oReady_AM_Accum0, 1'b1);
    tick();
    checkOutput("stall_b_v0", oValid_BM_State0, 1'b1);
    checkOutput("stall_b_v1", oValid_BM_State1, 1'b1);
    checkOutput("stall_b_d0", oData_BM_State0, 8'h43);
    checkOutput("stall_b_d1", oData_BM_State1, 8'h43);
    applyStimulus(1'b0, 1'b1, 2'd0, 0, 0);
    tick();
    checkOutput("stall_end_v0", oValid_BM_State0, 1'b0);
    checkOutput("stall_end_v1", oValid_BM_State1, 1'b0);

    // TEST mode, 8 back-to-back beats, State1 ready held low
    iReady_BM_State1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 2'd0, i, i - 4);
      tick();
      expData = {4'(i - 4), 4'(i)};
      checkOutput("test8_d0", oData_BM_State0, expData);
      checkOutput("test8_v0", oValid_BM_State0, 1'b1);
      checkOutput("test8_v1", oValid_BM_State1, 1'b0);
      checkOutput("test8_ready", oReady_AM_Accum0, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 2'd0, 0, 0);
    tick();
    checkOutput("test8_end_v0", oValid_BM_State0, 1'b0);
    checkSat("test8_sat", 16'd2);
    iReady_BM_State1 = 1'b1;

    // Counter saturation at 16'hFFFF and clear winning over an accept
`ifdef NEURON_ACT_SATCNT_EN
    iClrSat = 1'b1;
    tick();
    iClrSat = 1'b0;
    applyStimulus(1'b1, 1'b0, 2'd0, 20, 20);
    for (int i = 0; i < 32767; i++) tick();
    checkOutput("satcnt_fffe", oSatCnt, 16'hFFFE);
    tick();
    checkOutput("satcnt_ffff", oSatCnt, 16'hFFFF);
    tick();
    checkOutput("satcnt_hold", oSatCnt, 16'hFFFF);
    iClrSat = 1'b1;
    tick();
    checkOutput("satcnt_clr_accept", oSatCnt, 16'h0);
    checkOutput("satcnt_clr_v0", oValid_BM_State0, 1'b1);
    iClrSat = 1'b0;
`else
    applyStimulus(1'b1, 1'b0, 2'd0, 20, 20);
    tick();
    iClrSat = 1'b1;
    tick();
    iClrSat = 1'b0;
    checkOutput("satcnt_off", oSatCnt, 16'h0);
    checkOutput("satcnt_off_d0", oData_BM_State0, 8'h77);
`endif
    applyStimulus(1'b0, 1'b0, 2'd0, 0, 0);
    tick();

    // Reset pulse while both slots hold data
    iReady_BM_State0 = 1'b0;
    iReady_BM_State1 = 1'b0;
    applyStimulus(1'b1, 1'b1, 2'd0, 2, -3);
    tick();
    checkOutput("prerst_v0", oValid_BM_State0, 1'b1);
    checkOutput("prerst_v1", oValid_BM_State1, 1'b1);
    checkOutput("prerst_d1", oData_BM_State1, 8'hD2);
    applyStimulus(1'b0, 1'b1, 2'd0, 0, 0);
    #1 iRST = 1'b0;
    #1;
    checkOutput("midrst_v0", oValid_BM_State0, 1'b0);
    checkOutput("midrst_v1", oValid_BM_State1, 1'b0);
    checkOutput("midrst_d0", oData_BM_State0, 8'h00);
    checkOutput("midrst_d1", oData_BM_State1, 8'h00);
    checkOutput("midrst_sat", oSatCnt, 16'h0);
    #1 iRST = 1'b1;
    iReady_BM_State0 = 1'b1;
    iReady_BM_State1 = 1'b1;
    applyStimulus(1'b1, 1'b1, 2'd0, 5, 6);
    tick();
    checkOutput("postrst_v0", oValid_BM_State0, 1'b1);
    checkOutput("postrst_v1", oValid_BM_State1, 1'b1);
    checkOutput("postrst_d0", oData_BM_State0, 8'h65);
    checkOutput("postrst_d1", oData_BM_State1, 8'h65);
    checkSat("postrst_sat", 16'd0);
    applyStimulus(1'b0, 1'b0, 2'd0, 0, 0);
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
